uart_tx_fifo: RTL and testbench

Byte buffer and launch controller that sits directly upstream of the UART transmitter. Producers push bytes at full clock rate through a simple strobe interface; the block stores them in a DEPTH-entry FIFO and feeds them one at a time to the transmitter's data-valid/byte inputs. It then watches the transmitter's active/done outputs so that no byte is issued while a frame is in flight.

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter. It launches one stored byte per frame
// and waits for the transmitter's active/done handshake before it issues the next one.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    input  logic              i_Clr_Ovf,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_WAIT_ACT  = 2'b01,
        S_WAIT_DONE = 2'b10
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W:0]     count_reg, count_next;
    logic                overflow_reg, overflow_next;
    logic                tx_dv_reg;
    logic [7:0]          tx_byte_reg;
    logic                wr_accept;
    logic                wr_drop;
    logic                pop;

    assign o_Full     = (count_reg == DEPTH_CNT);
    assign o_Empty    = (count_reg == '0);
    assign o_Count    = count_reg;
    assign o_Overflow = overflow_reg;
    assign o_Tx_DV    = tx_dv_reg;
    assign o_Tx_Byte  = tx_byte_reg;
    assign o_Busy     = !o_Empty || (state_reg != S_IDLE);

    // Full is judged on the start-of-cycle count, so a pop in the same cycle
    // never rescues a write that arrives while full.
    assign wr_accept = i_Wr_DV && !o_Full;
    assign wr_drop   = i_Wr_DV && o_Full;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
                    pop        = 1'b1;
                    state_next = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (i_Tx_Done)
                    state_next = S_IDLE;
                else if (i_Tx_Active)
                    state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !pop)
            count_next = count_reg + 1'b1;
        else if (!wr_accept && pop)
            count_next = count_reg - 1'b1;
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (wr_drop)
            overflow_next = 1'b1;
        else if (i_Clr_Ovf)
            overflow_next = 1'b0;
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge i_Clock) begin
        if (wr_accept)
            mem[wr_ptr_reg] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            tx_dv_reg    <= 1'b0;
            tx_byte_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            tx_dv_reg    <= pop;
            if (wr_accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                tx_byte_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A queue-based reference model is checked every cycle.
// A behavioural UART transmitter/receiver pair closes the active/done handshake loop.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_dv = 1'b0;
    logic [7:0]        wr_byte = 8'h00;
    logic              clr_ovf = 1'b0;
    logic              force_active = 1'b0;
    logic              model_active = 1'b0;
    logic              model_done = 1'b0;
    logic              tx_serial = 1'b1;
    logic              tx_active;
    logic              tx_done;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Busy;

    assign tx_active = model_active | force_active;
    assign tx_done   = model_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .i_Clr_Ovf   (clr_ovf),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Busy      (o_Busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a "frame outstanding" flag.
    logic [7:0] q[$];
    bit         in_frame;
    bit         exp_dv;
    logic [7:0] exp_byte;
    bit         exp_ovf;

    task automatic model_reset();
        q.delete();
        in_frame = 1'b0;
        exp_dv   = 1'b0;
        exp_byte = 8'h00;
        exp_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit full;
        bit launch;
        full   = (q.size() == DEPTH);
        launch = !in_frame && (q.size() != 0) && !tx_active && !tx_done;
        exp_dv = launch;
        if (launch) begin
            exp_byte = q.pop_front();
            in_frame = 1'b1;
        end else if (in_frame && tx_done) begin
            in_frame = 1'b0;
        end
        if (wr_dv && !full)
            q.push_back(wr_byte);
        if (wr_dv && full)
            exp_ovf = 1'b1;
        else if (clr_ovf)
            exp_ovf = 1'b0;
    endtask

    task automatic model_compare();
        check("count", 32'(o_Count), 32'(q.size()));
        check("empty", 32'(o_Empty), 32'(q.size() == 0));
        check("full", 32'(o_Full), 32'(q.size() == DEPTH));
        check("overflow", 32'(o_Overflow), 32'(exp_ovf));
        check("busy", 32'(o_Busy), 32'((q.size() != 0) || in_frame));
        check("tx_dv", 32'(o_Tx_DV), 32'(exp_dv));
        check("tx_byte", 32'(o_Tx_Byte), 32'(exp_byte));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step();
                #1;
                model_compare();
            end
        end
    end

    // Behavioural transmitter: one frame per launch, done held for done_len cycles.
    int         done_len = 1;
    logic [7:0] log_q[$];
    logic [7:0] tx_shift;
    initial forever begin
        @(negedge clk);
        if (o_Tx_DV === 1'b1) begin
            log_q.push_back(o_Tx_Byte);
            $display("launch byte %02h (fifo count %0d)", o_Tx_Byte, o_Count);
            tx_shift     = o_Tx_Byte;
            model_active = 1'b1;
            tx_serial    = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                tx_serial = tx_shift[i];
                repeat (CPB) @(negedge clk);
            end
            tx_serial = 1'b1;
            repeat (CPB) @(negedge clk);
            model_active = 1'b0;
            model_done   = 1'b1;
            repeat (done_len) @(negedge clk);
            model_done = 1'b0;
        end
    end

    // Serial receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    logic [7:0] rx_shift;
    bit         stop_ok = 1'b0;
    initial forever begin
        @(posedge clk);
        if (tx_serial == 1'b0) begin
            @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                rx_shift[i] = tx_serial;
            end
            repeat (CPB) @(posedge clk);
            stop_ok = (tx_serial == 1'b1);
            rx_q.push_back(rx_shift);
        end
    end

    // Cycles between the last edge that saw done high and the edge that launched.
    int cyc = 0;
    int last_done_cyc = 0;
    int last_gap = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (tx_done)
            last_done_cyc = cyc;
        #1;
        if (o_Tx_DV)
            last_gap = cyc - last_done_cyc;
    end

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_dv   = 1'b1;
            wr_byte = 8'(first + i);
        end
        @(negedge clk);
        wr_dv = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((o_Busy || tx_active || tx_done) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", 32'(n < max_cycles), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_dv"}, 32'(o_Tx_DV), 32'd0);
        check({tag, "_tx_byte"}, 32'(o_Tx_Byte), 32'h00);
        check({tag, "_full"}, 32'(o_Full), 32'd0);
        check({tag, "_empty"}, 32'(o_Empty), 32'd1);
        check({tag, "_count"}, 32'(o_Count), 32'd0);
        check({tag, "_overflow"}, 32'(o_Overflow), 32'd0);
        check({tag, "_busy"}, 32'(o_Busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Single byte: launch visible one edge after the write edge.
        log_q.delete();
        rx_q.delete();
        @(negedge clk);
        wr_dv   = 1'b1;
        wr_byte = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        wr_dv = 1'b0;
        @(posedge clk);
        #2;
        check("single_dv", 32'(o_Tx_DV), 32'd1);
        check("single_byte", 32'(o_Tx_Byte), 32'hA5);
        wait_drain(200);
        check("single_launches", 32'(log_q.size()), 32'd1);
        check("single_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0)
            check("single_rx_byte", 32'(rx_q[0]), 32'hA5);
        check("single_stop_bit", 32'(stop_ok), 32'd1);

        // Asynchronous reset with 5 bytes buffered.
        log_q.delete();
        force_active = 1'b1;
        write_bytes(8'h40, 5);
        check("pre_reset_count", 32'(o_Count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        write_bytes(8'h55, 1);
        repeat (10) @(negedge clk);
        check("post_reset_no_launch", 32'(log_q.size()), 32'd0);
        force_active = 1'b0;
        wait_drain(200);
        check("post_reset_launches", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0)
            check("post_reset_byte", 32'(log_q[0]), 32'h55);

        // Burst to full, dropped write (with a clear in the same cycle), ordered drain.
        log_q.delete();
        force_active = 1'b1;
        write_bytes(8'h00, 16);
        @(negedge clk);
        wr_dv   = 1'b1;
        wr_byte = 8'hFF;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_dv   = 1'b0;
        clr_ovf = 1'b0;
        check("burst_full", 32'(o_Full), 32'd1);
        check("burst_count", 32'(o_Count), 32'd16);
        check("burst_overflow", 32'(o_Overflow), 32'd1);
        force_active = 1'b0;
        wait_drain(2000);
        check("burst_launches", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            check($sformatf("burst_order_%0d", i), 32'(log_q[i]), 32'(i));
        check("burst_overflow_sticky", 32'(o_Overflow), 32'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("overflow_cleared", 32'(o_Overflow), 32'd0);

        // Simultaneous write and pop at count 3.
        log_q.delete();
        force_active = 1'b1;
        write_bytes(8'h20, 3);
        force_active = 1'b0;
        wr_dv   = 1'b1;
        wr_byte = 8'h23;
        @(negedge clk);
        wr_dv = 1'b0;
        check("simul_count", 32'(o_Count), 32'd3);
        wait_drain(1000);
        check("simul_launches", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check($sformatf("simul_order_%0d", i), 32'(log_q[i]), 32'(8'h20 + i));

        // Gating on active, then done held for 3 cycles.
        log_q.delete();
        force_active = 1'b1;
        write_bytes(8'h30, 2);
        repeat (50) @(negedge clk);
        check("gate_no_launch", 32'(log_q.size()), 32'd0);
        done_len     = 3;
        force_active = 1'b0;
        wait_drain(500);
        check("gate_launches", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("gate_byte0", 32'(log_q[0]), 32'h30);
            check("gate_byte1", 32'(log_q[1]), 32'h31);
        end
        check("done_hold_gap", 32'(last_gap), 32'd1);
        done_len = 1;

        // Wrap-around stream of 40 bytes.
        log_q.delete();
        for (int c = 0; c < 4; c++) begin
            int n;
            write_bytes(8'(8'h10 + 10 * c), 10);
            n = 0;
            while (o_Count > 4 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("wrap_wait_budget", 32'(n < 2000), 32'd1);
        end
        wait_drain(2000);
        check("wrap_launches", 32'(log_q.size()), 32'd40);
        for (int i = 0; i < 40 && i < log_q.size(); i++)
            check($sformatf("wrap_order_%0d", i), 32'(log_q[i]), 32'(8'h10 + i));
        check("wrap_overflow", 32'(o_Overflow), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
